// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit: FSM states,
// data-memory access codes and the byte-count helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] BYTE  = 3'b000;
  localparam logic [2:0] HALF  = 3'b001;
  localparam logic [2:0] WORD  = 3'b010;
  localparam logic [2:0] BYTEU = 3'b100;
  localparam logic [2:0] HALFU = 3'b101;

  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // Index of the final byte beat (N-1) for a legal size code.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled load value to 32 bits.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        unsigned_flag,
  output logic [31:0] ext
);

  always_comb begin
    // NOTE: assigning a default first means every path drives ext, so no latch is inferred.
    ext = raw;
    case (size)
      2'b00:   ext = unsigned_flag ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   ext = unsigned_flag ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: ext = raw;  // word loads ignore the unsigned flag
    endcase
  end

endmodule

// File: rtl/byte_serial_lsu.sv
// Load/store unit that splits each core access into single-byte memory
// beats, little-endian, and returns one extended result pulse.
module byte_serial_lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] ReqAddress,
  input  logic [31:0] ReqDataWr,
  input  logic [2:0]  ReqCtrl,
  input  logic        ReqWr,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        RespErr,
  output logic [31:0] Address,
  output logic [31:0] DataWr,
  output logic [2:0]  DMCtrl,
  output logic        DMWr,
  input  logic [31:0] DataRd
);

  state_t      state, state_next;
  logic [31:0] base;
  logic [31:0] data;
  logic [2:0]  ctrl;
  logic        wr;
  logic [1:0]  idx;
  logic [1:0]  last;
  logic [31:0] result;
  logic [31:0] ext;
  logic        err;

  assign err = (ctrl[1:0] == SIZE_ILLEGAL);

  load_extend u_load_extend (
    .raw           (result),
    .size          (ctrl[1:0]),
    .unsigned_flag (ctrl[2]),
    .ext           (ext)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (rst) begin
      state  <= IDLE;
      base   <= '0;
      data   <= '0;
      ctrl   <= '0;
      wr     <= 1'b0;
      idx    <= '0;
      last   <= '0;
      result <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (ReqValid) begin
            base   <= ReqAddress;
            data   <= ReqDataWr;
            ctrl   <= ReqCtrl;
            wr     <= ReqWr;
            idx    <= '0;
            last   <= last_idx(ReqCtrl[1:0]);
            result <= '0;
          end
        end
        ACCESS: begin
          if (!wr) result[{idx, 3'b000} +: 8] <= DataRd[7:0];
          idx <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    ReqReady   = 1'b0;
    RespValid  = 1'b0;
    RespData   = '0;
    RespErr    = 1'b0;
    Address    = '0;
    DataWr     = '0;
    DMCtrl     = BYTE;
    DMWr       = 1'b0;
    case (state)
      IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) state_next = (ReqCtrl[1:0] == SIZE_ILLEGAL) ? RESP : ACCESS;
      end
      ACCESS: begin
        // 32-bit sum wraps naturally past 0xFFFFFFFF.
        Address = base + {30'h0, idx};
        if (wr) begin
          DMCtrl = BYTE;
          DMWr   = 1'b1;
          DataWr = {24'h0, data[{idx, 3'b000} +: 8]};
        end else begin
          DMCtrl = BYTEU;
        end
        if (idx == last) state_next = RESP;
      end
      RESP: begin
        RespValid  = 1'b1;
        RespErr    = err;
        RespData   = (err || wr) ? 32'h0 : ext;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_byte_serial_lsu.sv
// Directed bench: byte_serial_lsu paired with a small byte-wide data memory.
module tb_byte_serial_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ReqValid;
  logic        ReqReady;
  logic [31:0] ReqAddress;
  logic [31:0] ReqDataWr;
  logic [2:0]  ReqCtrl;
  logic        ReqWr;
  logic        RespValid;
  logic [31:0] RespData;
  logic        RespErr;
  logic [31:0] Address;
  logic [31:0] DataWr;
  logic [2:0]  DMCtrl;
  logic        DMWr;
  logic [31:0] DataRd;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  byte_serial_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqAddress (ReqAddress),
    .ReqDataWr  (ReqDataWr),
    .ReqCtrl    (ReqCtrl),
    .ReqWr      (ReqWr),
    .RespValid  (RespValid),
    .RespData   (RespData),
    .RespErr    (RespErr),
    .Address    (Address),
    .DataWr     (DataWr),
    .DMCtrl     (DMCtrl),
    .DMWr       (DMWr),
    .DataRd     (DataRd)
  );

  // Data memory model: 16 bytes decoded by Address[3:0], so 0xFFFFFFFF and 0 are distinct.
  bit [7:0]    mem [16];
  logic [39:0] wlog [$];

  assign DataRd = {24'h0, mem[Address[3:0]]};

  always @(posedge clk) begin
    if (DMWr) begin
      mem[Address[3:0]] <= DataWr[7:0];
      wlog.push_back({Address, DataWr[7:0]});
    end
  end

  int resp_seen = 0;
  always @(posedge clk) if (!rst && RespValid) resp_seen <= resp_seen + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge with the DUT idle; returns response and latency.
  task automatic run_req(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] ctrl, input logic wr,
                         output logic [31:0] rdata, output logic rerr, output int lat);
    ReqAddress = addr;
    ReqDataWr  = wdata;
    ReqCtrl    = ctrl;
    ReqWr      = wr;
    ReqValid   = 1'b1;
    @(posedge clk); #1;
    ReqValid = 1'b0;
    rdata = 'x;
    rerr  = 1'bx;
    lat   = 0;
    for (int c = 1; c <= 10; c++) begin
      if (RespValid) begin
        rdata = RespData;
        rerr  = RespErr;
        lat   = c;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat == 0) check("resp_timeout", 32'(lat), 32'd1);
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    rst = 1'b1; ReqValid = 1'b0; ReqAddress = '0; ReqDataWr = '0; ReqCtrl = '0; ReqWr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",   {31'h0, ReqReady},  32'd1);
    check("rst_rvalid",  {31'h0, RespValid}, 32'd0);
    check("rst_rdata",   RespData,           32'h0);
    check("rst_rerr",    {31'h0, RespErr},   32'd0);
    check("rst_addr",    Address,            32'h0);
    check("rst_datawr",  DataWr,             32'h0);
    check("rst_dmctrl",  {29'h0, DMCtrl},    32'h0);
    check("rst_dmwr",    {31'h0, DMWr},      32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Store word 0x80000001 at 3.
    wlog.delete();
    run_req(32'h3, 32'h8000_0001, 3'b010, 1'b1, rd, er, lat);
    check("sw_lat",   32'(lat), 32'd5);
    check("sw_nwr",   32'(wlog.size()), 32'd4);
    if (wlog.size() == 4) begin
      check("sw_a0", wlog[0][39:8], 32'h3); check("sw_d0", {24'h0, wlog[0][7:0]}, 32'h01);
      check("sw_a1", wlog[1][39:8], 32'h4); check("sw_d1", {24'h0, wlog[1][7:0]}, 32'h00);
      check("sw_a2", wlog[2][39:8], 32'h5); check("sw_d2", {24'h0, wlog[2][7:0]}, 32'h00);
      check("sw_a3", wlog[3][39:8], 32'h6); check("sw_d3", {24'h0, wlog[3][7:0]}, 32'h80);
    end
    check("sw_rdata", rd, 32'h0);
    check("sw_rerr",  {31'h0, er}, 32'd0);
    check("sw_ready", {31'h0, ReqReady}, 32'd1);

    // Load word at 3.
    wlog.delete();
    run_req(32'h3, 32'h0, 3'b010, 1'b0, rd, er, lat);
    check("lw_data", rd, 32'h8000_0001);
    check("lw_lat",  32'(lat), 32'd5);
    check("lw_nwr",  32'(wlog.size()), 32'd0);

    // Half store / signed and unsigned half loads at 1.
    run_req(32'h1, 32'h0000_FFFE, 3'b001, 1'b1, rd, er, lat);
    check("sh_lat", 32'(lat), 32'd3);
    run_req(32'h1, 32'h0, 3'b001, 1'b0, rd, er, lat);
    check("lh_data", rd, 32'hFFFF_FFFE);
    run_req(32'h1, 32'h0, 3'b101, 1'b0, rd, er, lat);
    check("lhu_data", rd, 32'h0000_FFFE);

    // Byte store / signed and unsigned byte loads at 0.
    run_req(32'h0, 32'h0000_00F8, 3'b000, 1'b1, rd, er, lat);
    check("sb_lat", 32'(lat), 32'd2);
    run_req(32'h0, 32'h0, 3'b000, 1'b0, rd, er, lat);
    check("lb_data", rd, 32'hFFFF_FFF8);
    run_req(32'h0, 32'h0, 3'b100, 1'b0, rd, er, lat);
    check("lbu_data", rd, 32'h0000_00F8);

    // Illegal size code.
    wlog.delete();
    run_req(32'h2, 32'h1234_5678, 3'b011, 1'b1, rd, er, lat);
    check("err_lat",  32'(lat), 32'd1);
    check("err_flag", {31'h0, er}, 32'd1);
    check("err_data", rd, 32'h0);
    check("err_nwr",  32'(wlog.size()), 32'd0);

    // Half store wrapping past the top of the address space.
    wlog.delete();
    run_req(32'hFFFF_FFFF, 32'h0000_ABCD, 3'b001, 1'b1, rd, er, lat);
    check("wrap_nwr", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      check("wrap_a0", wlog[0][39:8], 32'hFFFF_FFFF); check("wrap_d0", {24'h0, wlog[0][7:0]}, 32'hCD);
      check("wrap_a1", wlog[1][39:8], 32'h0000_0000); check("wrap_d1", {24'h0, wlog[1][7:0]}, 32'hAB);
    end

    // Reset during a word store: only the first two bytes land.
    run_req(32'h8, 32'h1122_3344, 3'b010, 1'b1, rd, er, lat);
    resp_seen = 0;
    ReqAddress = 32'h8; ReqDataWr = 32'hAABB_CCDD; ReqCtrl = 3'b010; ReqWr = 1'b1; ReqValid = 1'b1;
    @(posedge clk); #1;
    ReqValid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_ready", {31'h0, ReqReady}, 32'd1);
    check("mid_dmwr",  {31'h0, DMWr},     32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("mid_noresp", 32'(resp_seen), 32'd0);
    run_req(32'h8, 32'h0, 3'b010, 1'b0, rd, er, lat);
    check("mid_mem", rd, 32'h1122_CCDD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/byte_serial_lsu.md
BYTE_SERIAL_LSU -- requirements
Module: byte_serial_lsu

Interface
REQ-001 The block SHALL have no parameters; all data and address widths are fixed at 32 bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port: clk  in  1  system clock, all state updates on the rising edge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: ReqValid  in  1  core request present.
REQ-006 Port: ReqReady  out  1  block can accept a request this cycle.
REQ-007 Port: ReqAddress  in  32  byte address of the access.
REQ-008 Port: ReqDataWr  in  32  store data, right-aligned.
REQ-009 Port: ReqCtrl  in  3  access code: bits[1:0] set size (00 = byte, 01 = half, 10 = word, 11 = illegal); bit[2] = 1 selects an unsigned load.
REQ-010 Port: ReqWr  in  1  1 = store, 0 = load.
REQ-011 Port: RespValid  out  1  single-cycle completion pulse.
REQ-012 Port: RespData  out  32  extended load result; 0 for stores and errors.
REQ-013 Port: RespErr  out  1  illegal ReqCtrl, qualified by RespValid.
REQ-014 Port: Address  out  32  data-memory byte address.
REQ-015 Port: DataWr  out  32  data-memory write data.
REQ-016 Port: DMCtrl  out  3  data-memory access code.
REQ-017 Port: DMWr  out  1  data-memory write enable.
REQ-018 Port: DataRd  in  32  data-memory read data, valid in the same cycle as Address and DMCtrl.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-020 ReqReady SHALL be 1 only in IDLE, and ReqValid SHALL be ignored in all other states.
REQ-021 On ReqValid && ReqReady the block SHALL capture address, data, ctrl and wr, set byte count N (1, 2 or 4 from ReqCtrl[1:0]), clear index idx, and go to ACCESS.
REQ-022 If ReqCtrl[1:0] = 11 the block SHALL skip ACCESS, go directly to RESP, drive no memory access, and set RespErr = 1.
REQ-023 In ACCESS the block SHALL drive Address = base + idx, truncated modulo 2^32 so that 0xFFFFFFFF + 1 wraps to 0x00000000.
REQ-024 In ACCESS, stores SHALL drive DMCtrl = 000, DMWr = 1 and DataWr = {24'b0, data byte idx}, using little-endian lane order.
REQ-025 In ACCESS, loads SHALL drive DMCtrl = 100, DMWr = 0 and DataWr = 0, and SHALL capture DataRd[7:0] into result byte lane idx at the clock edge.
REQ-026 idx SHALL increment once per ACCESS cycle; after the cycle with idx = N-1 the FSM SHALL go to RESP.
REQ-027 In RESP, RespValid SHALL be 1 for exactly one cycle; the next state is always IDLE.
REQ-028 For loads, RespData SHALL be sign-extended from bit 8N-1 when ctrl[2] = 0 and zero-extended when ctrl[2] = 1; a word load SHALL ignore ctrl[2].
REQ-029 For stores and errors, RespData SHALL be 0, and RespErr SHALL be 0 on every legal access.
REQ-030 Latency SHALL be N+1 cycles from the acceptance edge to RespValid; the next request can be accepted in the cycle after RESP.
REQ-031 Outside ACCESS the memory outputs SHALL hold their idle values: Address = 0, DataWr = 0, DMCtrl = 000, DMWr = 0.
REQ-032 The response SHALL have no back-pressure: RespValid is a pulse and is never held.

Reset
REQ-033 With rst = 1 at a clock edge the block SHALL enter IDLE with idx = 0 and captured registers = 0.
REQ-034 After reset the outputs SHALL be ReqReady = 1, RespValid = 0, RespData = 0, RespErr = 0, and all memory outputs at their idle values.
REQ-035 Reset mid-operation SHALL abandon the access with no RespValid; bytes already written stay in memory.

Structure
REQ-036 A shared package lsu_pkg SHALL hold the state enum (IDLE, ACCESS, RESP) and the DMCtrl code constants: BYTE = 000, HALF = 001, WORD = 010, BYTEU = 100, HALFU = 101.
REQ-037 Sign and zero extension SHALL be a combinational sub-module load_extend, with inputs raw[31:0], size[1:0], unsigned_flag and output ext[31:0].

Verification
REQ-038 The bench SHALL pair the block with the datamemory model and cover the following scenarios.
REQ-039 Scenario 1: store word 0x80000001 at address 3 -> four DMWr cycles at addresses 3, 4, 5, 6 with data bytes 01, 00, 00, 80; RespValid in cycle 5 after acceptance.
REQ-040 Scenario 2: load word at address 3 (ctrl 010) -> RespData = 0x80000001.
REQ-041 Scenario 3: store half 0xFFFE at address 1, then load half at address 1 -> ctrl 001 gives RespData = 0xFFFFFFFE, and ctrl 101 gives 0x0000FFFE.
REQ-042 Scenario 4: store byte 0xF8 at address 0, then load byte at address 0 -> ctrl 000 gives 0xFFFFFFF8, and ctrl 100 gives 0x000000F8.
REQ-043 Scenario 5: request with ReqCtrl = 011 -> no DMWr, RespValid one cycle after acceptance, RespErr = 1, RespData = 0.
REQ-044 Scenario 6: half store at address 0xFFFFFFFF -> byte accesses at 0xFFFFFFFF then 0x00000000.
REQ-045 Scenario 7: assert rst after the second byte of a word store -> ReqReady = 1 next cycle, no RespValid, and only two bytes modified in memory.
